mtr_drv_pwm: RTL and testbench
==============================

Name: mtr_drv_pwm

Overview:
- Motor-drive stage directly downstream of the PID steering block.
- Consumes the signed left/right wheel speeds and converts each into a complementary, dead-time-protected PWM pair for an H-bridge.
- A shared 11-bit period counter sets the PWM period. Duty is latched once per period so the outputs never glitch mid-period.

Parameters:
- PWM_W, 11: counter/duty width; period = 2^PWM_W clocks.
- DEAD_CYC, 8: dead-time clocks, both legs low, on every leg handover (1..255).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  drive enable; 0 = coast (all legs low).
- lft_spd  in  11  signed left wheel speed, -1024..+1023.
- rght_spd  in  11  signed right wheel speed.
- lftPWM1  out  1  left high-side leg.
- lftPWM2  out  1  left low-side leg.
- rghtPWM1  out  1  right high-side leg.
- rghtPWM2  out  1  right low-side leg.
- PWM_synch  out  1  one-clock pulse when the counter equals 0 (period start).

Behaviour:
- Reset (rst=1 at a clk edge):
  - cnt=0, both duty registers=0x400, both channel FSMs=OFF.
  - All four PWM outputs=0; PWM_synch=0.
- Counter:
  - cnt increments every clock and wraps 2047->0.
  - PWM_synch is registered and high during the cycle cnt==0.
- Duty load:
  - At the edge ending the cnt==2047 cycle: duty_x <= spd_x + 0x400, computed modulo 2^11 (offset binary).
  - -1024 maps to 0x000, 0 maps to 0x400, +1023 maps to 0x7FF.
  - The new duty takes effect from cnt==0. Speed changes within a period are ignored.
  - Load continues regardless of en.
- Raw PWM: raw_x = (cnt < duty_x), unsigned compare, combinational.
- Channel FSM (one per side), states OFF, LO, DEAD_TO_HI, HI, DEAD_TO_LO; dead_cnt is 8 bits:
  - OFF: outputs 00. If en=1, go to DEAD_TO_HI when raw=1, else DEAD_TO_LO, loading dead_cnt=DEAD_CYC-1.
  - LO: PWM2=1. If raw=1, go to DEAD_TO_HI and load dead_cnt.
  - HI: PWM1=1. If raw=0, go to DEAD_TO_LO and load dead_cnt.
  - DEAD_TO_HI: outputs 00. Evaluated in this order:
    - If raw=0, go to DEAD_TO_LO and reload.
    - Else if dead_cnt==0, go to HI.
    - Else decrement dead_cnt.
  - DEAD_TO_LO: symmetric to DEAD_TO_HI, with raw=1 going to DEAD_TO_HI and expiry going to LO.
  - en=0 in any state forces OFF at the next edge. rst has priority over en.
- Outputs:
  - Driven by registered state only, so there are no combinational paths from inputs.
  - PWM1 & PWM2 is never 1 in any cycle (invariant).
- Latency: a raw edge is followed by exactly DEAD_CYC cycles of 00, then the new leg asserts.
  - Duty 0x400, DEAD_CYC=8: PWM1 high for cnt 9..1024 (1016 clocks); PWM2 high for cnt 1033..2047 and cnt 0 of the next period (1016 clocks).
- Boundaries:
  - duty 0x000: raw is never 1; the channel stays LO, with PWM2 constantly high.
  - duty 0x7FF: raw is low only at cnt 2047. PWM1 is low for cnt 0..DEAD_CYC (DEAD_CYC+1 clocks) each period. PWM2 never asserts.
  - Reversal inside dead time restarts the dead time in the opposite direction, so sub-dead-time pulses are swallowed.
  - rst mid-period: all legs drop at the reset edge. The counter restarts from 0 with duty 0x400.

Decomposition:
- Package mtr_drv_pkg holds:
  - typedef enum pwm_ch_state_t {OFF, LO, DEAD_TO_HI, HI, DEAD_TO_LO};
  - localparams PWM_W, DUTY_MID (0x400), DEAD_CYC default.
- Sub-module pwm_dead_ch: per-channel raw compare, FSM and dead_cnt. Instantiated twice (left, right).
- The top owns cnt, PWM_synch and both duty registers.

Test Plan:
- rst held 3 clocks then released, en=1, spd=0 -> all outputs 0 during reset. PWM_synch pulses every 2048 clocks. After steady state each leg is high 1016 clocks per period.
- lft_spd=+512 (duty 0x600), DEAD_CYC=8 -> lftPWM1 high cnt 9..1536 (1528 clocks); lftPWM2 high 504 clocks; 8-clock 00 gap at each handover.
- rght_spd=-1024 -> rghtPWM2 continuously high, rghtPWM1 never high. rght_spd=+1023 -> rghtPWM1 low 9 clocks per period, rghtPWM2 never high.
- Change lft_spd from 0 to +300 at cnt=100 -> duty unchanged until the cnt 2047->0 edge; the new duty 0x52C applies from the next period.
- Drop en at cnt=500 mid-HI -> next edge all legs 0. Raise en at cnt=1200 -> 8 clocks of 00, then lftPWM2=1.
- Assert rst for 1 clock mid-DEAD_TO_HI -> outputs 0, cnt=0, duty 0x400. Checker asserts PWM1&PWM2==0 every cycle over a random speed sweep.

Source files
------------

// File: rtl/mtr_drv_pkg.sv
// rtl/mtr_drv_pkg.sv - shared constants and channel state type for the motor PWM stage
package mtr_drv_pkg;

    localparam int PWM_W = 11;
    localparam logic [PWM_W-1:0] DUTY_MID = 11'h400;
    localparam int DEAD_CYC = 8;

    typedef enum logic [2:0] {
        OFF        = 3'd0,
        LO         = 3'd1,
        DEAD_TO_HI = 3'd2,
        HI         = 3'd3,
        DEAD_TO_LO = 3'd4
    } pwm_ch_state_t;

endpackage

// File: rtl/pwm_dead_ch.sv
// rtl/pwm_dead_ch.sv - one H-bridge channel: raw compare plus dead-time handover FSM
module pwm_dead_ch #(
    parameter int PWM_W    = mtr_drv_pkg::PWM_W,
    parameter int DEAD_CYC = mtr_drv_pkg::DEAD_CYC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [PWM_W-1:0] cnt,
    input  logic [PWM_W-1:0] duty,
    output logic             pwm1,
    output logic             pwm2
);
    import mtr_drv_pkg::*;

    // dead_cnt counts down to zero, so DEAD_CYC-1 gives exactly DEAD_CYC idle clocks
    localparam logic [7:0] DEAD_LD = 8'(DEAD_CYC - 1);

    logic          raw;
    pwm_ch_state_t state;
    logic [7:0]    dead_cnt;

    // Raw PWM: high while the period counter is below the latched duty
    assign raw = (cnt < duty);

    // Leg handover FSM: every change of leg passes through a dead window with both legs off;
    // a reversal inside the window restarts it towards the other leg
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= OFF;
            dead_cnt <= '0;
        end else if (!en) begin
            state <= OFF;
        end else begin
            case (state)
                OFF: begin
                    state    <= raw ? DEAD_TO_HI : DEAD_TO_LO;
                    dead_cnt <= DEAD_LD;
                end
                LO: begin
                    if (raw) begin
                        state    <= DEAD_TO_HI;
                        dead_cnt <= DEAD_LD;
                    end
                end
                HI: begin
                    if (!raw) begin
                        state    <= DEAD_TO_LO;
                        dead_cnt <= DEAD_LD;
                    end
                end
                DEAD_TO_HI: begin
                    if (!raw) begin
                        state    <= DEAD_TO_LO;
                        dead_cnt <= DEAD_LD;
                    end else if (dead_cnt == 8'd0) begin
                        state <= HI;
                    end else begin
                        dead_cnt <= dead_cnt - 8'd1;
                    end
                end
                DEAD_TO_LO: begin
                    if (raw) begin
                        state    <= DEAD_TO_HI;
                        dead_cnt <= DEAD_LD;
                    end else if (dead_cnt == 8'd0) begin
                        state <= LO;
                    end else begin
                        dead_cnt <= dead_cnt - 8'd1;
                    end
                end
                default: begin
                    state <= OFF;
                end
            endcase
        end
    end

    // Legs decode only the registered state, so both can never be high together
    assign pwm1 = (state == HI);
    assign pwm2 = (state == LO);

endmodule

// File: rtl/mtr_drv_pwm.sv
// rtl/mtr_drv_pwm.sv - dual-channel dead-time protected PWM motor drive
module mtr_drv_pwm #(
    parameter int PWM_W    = mtr_drv_pkg::PWM_W,
    parameter int DEAD_CYC = mtr_drv_pkg::DEAD_CYC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [PWM_W-1:0] lft_spd,
    input  logic [PWM_W-1:0] rght_spd,
    output logic             lftPWM1,
    output logic             lftPWM2,
    output logic             rghtPWM1,
    output logic             rghtPWM2,
    output logic             PWM_synch
);
    import mtr_drv_pkg::*;

    // Mid-scale duty (zero speed) and the last count of a period
    localparam logic [PWM_W-1:0] MID     = {1'b1, {(PWM_W-1){1'b0}}};
    localparam logic [PWM_W-1:0] CNT_MAX = '1;

    logic [PWM_W-1:0] cnt;
    logic [PWM_W-1:0] duty_l;
    logic [PWM_W-1:0] duty_r;

    // Free-running period counter and registered period-start strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            PWM_synch <= 1'b0;
        end else begin
            cnt       <= cnt + 1'b1;
            PWM_synch <= (cnt == CNT_MAX);
        end
    end

    // Duty latch at the period boundary; signed speed becomes offset binary by adding mid-scale
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_l <= MID;
            duty_r <= MID;
        end else if (cnt == CNT_MAX) begin
            duty_l <= lft_spd + MID;
            duty_r <= rght_spd + MID;
        end
    end

    pwm_dead_ch #(
        .PWM_W   (PWM_W),
        .DEAD_CYC(DEAD_CYC)
    ) u_left (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .cnt (cnt),
        .duty(duty_l),
        .pwm1(lftPWM1),
        .pwm2(lftPWM2)
    );

    pwm_dead_ch #(
        .PWM_W   (PWM_W),
        .DEAD_CYC(DEAD_CYC)
    ) u_right (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .cnt (cnt),
        .duty(duty_r),
        .pwm1(rghtPWM1),
        .pwm2(rghtPWM2)
    );

endmodule

// File: tb/tb_mtr_drv_pwm.sv
// tb/tb_mtr_drv_pwm.sv - self-checking bench for mtr_drv_pwm
module tb_mtr_drv_pwm;

    localparam int PERIOD = 2048;
    localparam int DEAD   = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [10:0] lft_spd  = 11'd0;
    logic [10:0] rght_spd = 11'd0;
    logic        lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, PWM_synch;

    int checks   = 0;
    int failures = 0;

    // Reference model: period position, latched duties, and signed run length of the
    // raw waveform while enabled (positive = consecutive high samples, negative = low)
    int          m_cnt    = 0;
    logic [10:0] m_duty_l = 11'h400;
    logic [10:0] m_duty_r = 11'h400;
    int          run_l    = 0;
    int          run_r    = 0;
    logic        m_synch  = 1'b0;
    logic        e_l1 = 1'b0, e_l2 = 1'b0, e_r1 = 1'b0, e_r2 = 1'b0;

    mtr_drv_pwm dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .lft_spd  (lft_spd),
        .rght_spd (rght_spd),
        .lftPWM1  (lftPWM1),
        .lftPWM2  (lftPWM2),
        .rghtPWM1 (rghtPWM1),
        .rghtPWM2 (rghtPWM2),
        .PWM_synch(PWM_synch)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL timeout: simulation did not finish, got running required finished");
        $fatal(1, "timeout");
    end

    function automatic int next_run(int r, logic e, logic raw);
        if (!e) return 0;
        if (raw) return (r > 0) ? ((r < 1000000) ? r + 1 : r) : 1;
        return (r < 0) ? ((r > -1000000) ? r - 1 : r) : -1;
    endfunction

    // A leg is on once the raw level has held for the whole dead window plus the deciding sample
    task automatic tick();
        logic raw_l, raw_r;
        @(posedge clk);
        if (rst) begin
            m_cnt    = 0;
            m_duty_l = 11'h400;
            m_duty_r = 11'h400;
            run_l    = 0;
            run_r    = 0;
            m_synch  = 1'b0;
        end else begin
            raw_l   = (m_cnt < int'(m_duty_l));
            raw_r   = (m_cnt < int'(m_duty_r));
            run_l   = next_run(run_l, en, raw_l);
            run_r   = next_run(run_r, en, raw_r);
            m_synch = (m_cnt == PERIOD - 1);
            if (m_cnt == PERIOD - 1) begin
                m_duty_l = lft_spd + 11'h400;
                m_duty_r = rght_spd + 11'h400;
            end
            m_cnt = (m_cnt + 1) % PERIOD;
        end
        e_l1 = (run_l > DEAD);
        e_l2 = (run_l < -DEAD);
        e_r1 = (run_r > DEAD);
        e_r2 = (run_r < -DEAD);
        #1;
    endtask

    task automatic skip_period();
        repeat (PERIOD) tick();
    endtask

    task automatic wait_cnt(input int target);
        for (int i = 0; i < 2 * PERIOD && m_cnt != target; i++) tick();
    endtask

    // Counts leg-high cycles over one period starting at the current sample
    task automatic measure_period(output int h1l, output int h2l, output int h1r,
                                  output int h2r, output int syn);
        h1l = 0; h2l = 0; h1r = 0; h2r = 0; syn = 0;
        for (int i = 0; i < PERIOD; i++) begin
            h1l += int'(lftPWM1);
            h2l += int'(lftPWM2);
            h1r += int'(rghtPWM1);
            h2r += int'(rghtPWM2);
            syn += int'(PWM_synch);
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; lft_spd = 11'd0; rght_spd = 11'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, PWM_synch} !== 5'b0) begin
                failures++;
                $display("FAIL reset_outputs cycle %0d: got %b required 00000", i,
                         {lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, PWM_synch});
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_steady();
        int syn_cnt, shown, h1l, h2l, h1r, h2r, syn;
        syn_cnt = 0; shown = 0;
        for (int i = 0; i < 2 * PERIOD; i++) begin
            tick();
            syn_cnt += int'(PWM_synch);
            checks++;
            if ({lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, PWM_synch} !==
                {e_l1, e_l2, e_r1, e_r2, m_synch}) begin
                failures++;
                if (shown++ < 10)
                    $display("FAIL steady_model cnt %0d: got %b required %b", m_cnt,
                             {lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, PWM_synch},
                             {e_l1, e_l2, e_r1, e_r2, m_synch});
            end
        end
        checks++;
        if (syn_cnt != 2) begin
            failures++;
            $display("FAIL synch_count: got %0d required 2", syn_cnt);
        end
        measure_period(h1l, h2l, h1r, h2r, syn);
        checks++;
        if (h1l != 1016 || h2l != 1016 || h1r != 1016 || h2r != 1016) begin
            failures++;
            $display("FAIL steady_high_counts: got %0d/%0d/%0d/%0d required 1016 each",
                     h1l, h2l, h1r, h2r);
        end
    endtask

    task automatic test_duty();
        int h1l, h2l, h1r, h2r, syn;
        lft_spd  = 11'd512;
        rght_spd = 11'h400;            // -1024
        skip_period();
        measure_period(h1l, h2l, h1r, h2r, syn);
        checks++;
        if (h1l != 1528 || h2l != 504) begin
            failures++;
            $display("FAIL duty_600: got pwm1=%0d pwm2=%0d required 1528/504", h1l, h2l);
        end
        checks++;
        if (h1r != 0 || h2r != PERIOD) begin
            failures++;
            $display("FAIL duty_000: got pwm1=%0d pwm2=%0d required 0/2048", h1r, h2r);
        end
        rght_spd = 11'h3FF;            // +1023
        skip_period();
        skip_period();
        measure_period(h1l, h2l, h1r, h2r, syn);
        checks++;
        if (h1r != PERIOD - (DEAD + 1) || h2r != 0) begin
            failures++;
            $display("FAIL duty_7ff: got pwm1=%0d pwm2=%0d required 2039/0", h1r, h2r);
        end
    endtask

    task automatic test_mid_change();
        int h1l, h2l, h1r, h2r, syn;
        lft_spd = 11'd0; rght_spd = 11'd0;
        skip_period();
        h1l = 0;
        for (int i = 0; i < PERIOD; i++) begin
            h1l += int'(lftPWM1);
            if (m_cnt == 100) lft_spd = 11'd300;
            tick();
        end
        checks++;
        if (h1l != 1016) begin
            failures++;
            $display("FAIL mid_change_ignored: got %0d required 1016", h1l);
        end
        measure_period(h1l, h2l, h1r, h2r, syn);
        checks++;
        if (h1l != 1316 || h2l != 716) begin
            failures++;
            $display("FAIL duty_52c: got pwm1=%0d pwm2=%0d required 1316/716", h1l, h2l);
        end
    endtask

    task automatic test_enable();
        int bad;
        lft_spd = 11'd0;
        skip_period();
        wait_cnt(500);
        checks++;
        if (lftPWM1 !== 1'b1) begin
            failures++;
            $display("FAIL en_pre_hi: got %b required 1", lftPWM1);
        end
        en = 1'b0;
        tick();
        checks++;
        if ({lftPWM1, lftPWM2, rghtPWM1, rghtPWM2} !== 4'b0) begin
            failures++;
            $display("FAIL en_drop: got %b required 0000",
                     {lftPWM1, lftPWM2, rghtPWM1, rghtPWM2});
        end
        wait_cnt(1200);
        checks++;
        if ({lftPWM1, lftPWM2, rghtPWM1, rghtPWM2} !== 4'b0) begin
            failures++;
            $display("FAIL en_coast: got %b required 0000",
                     {lftPWM1, lftPWM2, rghtPWM1, rghtPWM2});
        end
        en = 1'b1;
        bad = 0;
        for (int i = 0; i < DEAD; i++) begin
            tick();
            if ({lftPWM1, lftPWM2} !== 2'b00) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL en_dead_window: got %0d non-idle cycles required 0", bad);
        end
        tick();
        checks++;
        if ({lftPWM1, lftPWM2} !== 2'b01) begin
            failures++;
            $display("FAIL en_to_lo: got %b required 01", {lftPWM1, lftPWM2});
        end
    endtask

    task automatic test_reset_mid();
        int h1l, h2l, h1r, h2r, syn;
        lft_spd = 11'd512;
        wait_cnt(0);
        wait_cnt(4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, PWM_synch} !== 5'b0) begin
            failures++;
            $display("FAIL reset_mid_outputs: got %b required 00000",
                     {lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, PWM_synch});
        end
        measure_period(h1l, h2l, h1r, h2r, syn);
        checks++;
        if (h1l != 1016 || h2l != 1015 || h1r != 1016 || h2r != 1015) begin
            failures++;
            $display("FAIL reset_mid_duty: got %0d/%0d/%0d/%0d required 1016/1015/1016/1015",
                     h1l, h2l, h1r, h2r);
        end
        checks++;
        if (syn != 0 || PWM_synch !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_synch: got early=%0d at_2048=%b required 0/1", syn, PWM_synch);
        end
    endtask

    task automatic test_random_sweep();
        int shown;
        shown = 0;
        for (int i = 0; i < 8 * PERIOD; i++) begin
            rst = ($urandom_range(0, 4999) == 0);
            if ($urandom_range(0, 1499) == 0) en = ~en;
            if ($urandom_range(0, 299) == 0) begin
                case ($urandom_range(0, 3))
                    0: lft_spd = 11'h400;
                    1: lft_spd = 11'h3FF;
                    default: lft_spd = 11'($urandom_range(0, 2047));
                endcase
            end
            if ($urandom_range(0, 299) == 0) rght_spd = 11'($urandom_range(0, 2047));
            tick();
            checks++;
            if ({lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, PWM_synch} !==
                {e_l1, e_l2, e_r1, e_r2, m_synch}) begin
                failures++;
                if (shown++ < 10)
                    $display("FAIL sweep_model cnt %0d: got %b required %b", m_cnt,
                             {lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, PWM_synch},
                             {e_l1, e_l2, e_r1, e_r2, m_synch});
            end
            checks++;
            if ((lftPWM1 & lftPWM2) !== 1'b0 || (rghtPWM1 & rghtPWM2) !== 1'b0) begin
                failures++;
                if (shown++ < 10)
                    $display("FAIL shoot_through cnt %0d: got %b required no overlap", m_cnt,
                             {lftPWM1, lftPWM2, rghtPWM1, rghtPWM2});
            end
        end
        rst = 1'b0;
        en  = 1'b1;
    endtask

    initial begin
        test_reset();
        test_steady();
        test_duty();
        test_mid_change();
        test_enable();
        test_reset_mid();
        test_random_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
